// File: rtl/bk_pulse_mon_pkg.sv
// Shared definitions for the breakdown feedback pulse monitor and its pulse generator.
// State encoding and nominal pulse timing, in 25 MHz cycles.
package bk_pulse_mon_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } bk_state_e;

    localparam int BK_PULSE_W     = 876;
    localparam int BK_PERIOD      = 500002;
    localparam int BK_HALF        = 250001;
    localparam int BK_SYNC_STAGES = 2;

endpackage

// File: rtl/bk_pulse_ch_mon.sv
// One feedback channel: synchroniser, optional glitch filter (BK_GLITCH_FILTER_EN),
// width/interval counters and the ARM/HIGH/LOW checker FSM.
module bk_pulse_ch_mon
    import bk_pulse_mon_pkg::*;
#(
`ifdef BK_GLITCH_FILTER_EN
    parameter int GLITCH_CYC = 4,
`endif
    parameter int CNT_W      = 19,
    parameter int WID_W      = 12,
    parameter int WIDTH_MIN  = 800,
    parameter int WIDTH_MAX  = 950,
    parameter int PERIOD_MIN = 200000,
    parameter int PERIOD_MAX = 510000
) (
    input  logic             i_clk_25m,
    input  logic             i_rst_n,
    input  logic             bk_pulse,
    input  logic             clr,
    output logic             width_err,
    output logic             period_err,
    output logic             timeout,
    output logic             pulse_ok,
    output logic [WID_W-1:0] width,
    output logic [CNT_W-1:0] period
);

    localparam int SYNC_N = BK_SYNC_STAGES;
    localparam logic [WID_W-1:0] W_ONE = WID_W'(1);
    localparam logic [WID_W-1:0] W_MIN = WID_W'(WIDTH_MIN);
    localparam logic [WID_W-1:0] W_MAX = WID_W'(WIDTH_MAX);
    localparam logic [WID_W-1:0] W_ERR = WID_W'(WIDTH_MAX + 1);
    localparam logic [CNT_W-1:0] P_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] P_MIN = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] P_TMO = CNT_W'(PERIOD_MAX + 1);

    logic [SYNC_N-1:0] sync_q;
    logic [SYNC_N-1:0] vld_pipe;
    logic              lvl, lvl_d, rise, fall;

    // vld_pipe marks when the sync chain holds real input samples; until then lvl_d
    // is pinned high so a pulse already in flight at reset release is not seen as a rise.
    always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q   <= '0;
            vld_pipe <= '0;
            lvl_d    <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_N-2:0], bk_pulse};
            vld_pipe <= {vld_pipe[SYNC_N-2:0], 1'b1};
            lvl_d    <= vld_pipe[SYNC_N-1] ? lvl : 1'b1;
        end
    end

`ifdef BK_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYC) + 1;
    logic [GW-1:0] stab_cnt;

    always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lvl      <= 1'b1;
            stab_cnt <= '0;
        end else if (!vld_pipe[SYNC_N-1] || sync_q[SYNC_N-1] == lvl) begin
            stab_cnt <= '0;
        end else if (stab_cnt == GW'(GLITCH_CYC - 1)) begin
            lvl      <= sync_q[SYNC_N-1];
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end
`else
    assign lvl = sync_q[SYNC_N-1];
`endif

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    bk_state_e        st, st_n;
    logic [WID_W-1:0] wid, wid_n, wid_inc, width_n;
    logic [CNT_W-1:0] per, per_n, per_inc, period_n;
    logic             werr_n, perr_n, tmo_n, ok_n;
    logic             rise_legal, rise_legal_n, tmo_hit;

    assign wid_inc = (wid == '1) ? wid : wid + 1'b1;
    assign per_inc = (per == '1) ? per : per + 1'b1;
    assign tmo_hit = (per != P_TMO) && (per_inc == P_TMO);

    always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st         <= ST_ARM;
            wid        <= '0;
            per        <= '0;
            width_err  <= 1'b0;
            period_err <= 1'b0;
            timeout    <= 1'b0;
            pulse_ok   <= 1'b0;
            width      <= '0;
            period     <= '0;
            rise_legal <= 1'b0;
        end else begin
            st         <= st_n;
            wid        <= wid_n;
            per        <= per_n;
            width_err  <= werr_n;
            period_err <= perr_n;
            timeout    <= tmo_n;
            pulse_ok   <= ok_n;
            width      <= width_n;
            period     <= period_n;
            rise_legal <= rise_legal_n;
        end
    end

    always_comb begin
        st_n         = st;
        wid_n        = wid;
        per_n        = per;
        werr_n       = width_err;
        perr_n       = period_err;
        tmo_n        = timeout;
        ok_n         = pulse_ok;
        width_n      = width;
        period_n     = period;
        rise_legal_n = rise_legal;
        if (clr) begin
            st_n         = ST_ARM;
            wid_n        = '0;
            per_n        = '0;
            werr_n       = 1'b0;
            perr_n       = 1'b0;
            tmo_n        = 1'b0;
            ok_n         = 1'b0;
            rise_legal_n = 1'b0;
        end else begin
            case (st)
                ST_ARM: begin
                    if (rise) begin
                        st_n         = ST_HIGH;
                        wid_n        = W_ONE;
                        per_n        = P_ONE;
                        rise_legal_n = 1'b0;
                    end else begin
                        per_n = per_inc;
                        if (tmo_hit) begin
                            tmo_n = 1'b1;
                            ok_n  = 1'b0;
                        end
                    end
                end
                ST_HIGH: begin
                    per_n = per_inc;
                    if (tmo_hit) begin
                        tmo_n = 1'b1;
                        ok_n  = 1'b0;
                    end
                    if (fall) begin
                        width_n = wid;
                        st_n    = ST_LOW;
                        if (wid < W_MIN || wid > W_MAX) begin
                            werr_n = 1'b1;
                            ok_n   = 1'b0;
                        end else if (rise_legal) begin
                            ok_n = 1'b1;
                        end
                    end else begin
                        wid_n = wid_inc;
                        // stuck high: flag as soon as the width is provably too long
                        if (wid != W_ERR && wid_inc == W_ERR) begin
                            werr_n = 1'b1;
                            ok_n   = 1'b0;
                        end
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        period_n = per;
                        st_n     = ST_HIGH;
                        wid_n    = W_ONE;
                        per_n    = P_ONE;
                        if (per < P_MIN) begin
                            perr_n       = 1'b1;
                            ok_n         = 1'b0;
                            rise_legal_n = 1'b0;
                        end else begin
                            rise_legal_n = 1'b1;
                        end
                    end else begin
                        per_n = per_inc;
                        if (tmo_hit) begin
                            tmo_n = 1'b1;
                            ok_n  = 1'b0;
                            st_n  = ST_ARM;
                        end
                    end
                end
                default: st_n = ST_ARM;
            endcase
        end
    end

endmodule

// File: rtl/bk_pulse_mon.sv
// Receive-side checker for the breakdown feedback pulses, one bk_pulse_ch_mon per channel.
// Build with BK_GLITCH_FILTER_EN to add the GLITCH_CYC stability filter on each input.
module bk_pulse_mon
    import bk_pulse_mon_pkg::*;
#(
`ifdef BK_GLITCH_FILTER_EN
    parameter int GLITCH_CYC = 4,
`endif
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 19,
    parameter int WID_W      = 12,
    parameter int WIDTH_MIN  = 800,
    parameter int WIDTH_MAX  = 950,
    parameter int PERIOD_MIN = 200000,
    parameter int PERIOD_MAX = 510000
) (
    input  logic                    i_clk_25m,
    input  logic                    i_rst_n,
    input  logic [NUM_CH-1:0]       i_bk_pulse,
    input  logic                    i_clr_fault,
    output logic [NUM_CH-1:0]       o_width_err,
    output logic [NUM_CH-1:0]       o_period_err,
    output logic [NUM_CH-1:0]       o_timeout,
    output logic [NUM_CH-1:0]       o_pulse_ok,
    output logic [NUM_CH*WID_W-1:0] o_width,
    output logic [NUM_CH*CNT_W-1:0] o_period
);

    logic [NUM_CH-1:0][WID_W-1:0] width_a;
    logic [NUM_CH-1:0][CNT_W-1:0] period_a;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        bk_pulse_ch_mon #(
`ifdef BK_GLITCH_FILTER_EN
            .GLITCH_CYC (GLITCH_CYC),
`endif
            .CNT_W      (CNT_W),
            .WID_W      (WID_W),
            .WIDTH_MIN  (WIDTH_MIN),
            .WIDTH_MAX  (WIDTH_MAX),
            .PERIOD_MIN (PERIOD_MIN),
            .PERIOD_MAX (PERIOD_MAX)
        ) u_ch (
            .i_clk_25m  (i_clk_25m),
            .i_rst_n    (i_rst_n),
            .bk_pulse   (i_bk_pulse[c]),
            .clr        (i_clr_fault),
            .width_err  (o_width_err[c]),
            .period_err (o_period_err[c]),
            .timeout    (o_timeout[c]),
            .pulse_ok   (o_pulse_ok[c]),
            .width      (width_a[c]),
            .period     (period_a[c])
        );
    end

    // packed per-channel arrays flatten with ch0 in the LSBs
    assign o_width  = width_a;
    assign o_period = period_a;

endmodule
